unidad_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit sitting directly downstream of `banco_registros`. It consumes the two read ports (`readData1`/`readData2`) plus the destination register index, and computes one of the eight M-extension operations over multiple cycles. It returns a single-cycle write-back pulse (`done`, `rd_out`, `result`) that drives the register file's `RegWrite`/`writeReg`/`writeData`.

---
 rtl/unidad_muldiv.sv | 132 +++++++++++++
 tb/tb_unidad_muldiv.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one radix-2 step per cycle, with a one-cycle write-back pulse for the register file.
module unidad_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

  localparam int W = WIDTH;
  localparam logic [4:0] LAST_STEP = 5'(W - 1);
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t         state, state_next;
  logic [4:0]     cnt;
  logic [2:0]     func;
  logic           neg_res;
  logic [2*W-1:0] acc, acc_step, prod;
  logic [W-1:0]   opnd, fin_val, core;
  logic           accept;

  logic           a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag, special_val;
  logic           div_zero, div_ovf, special;

  logic [W:0]     mul_sum, div_shift, div_diff;
  logic           div_ge;

  // A new request is taken in IDLE or on the FIN->IDLE edge, never mid-calculation.
  assign accept = start && ((state == IDLE) || (state == FIN));

  // Operand decode at accept: signedness, magnitudes and the divide special cases.
  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed && op_a[W-1];
    b_neg    = b_signed && op_b[W-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN_INT) && (op_b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_val = funct3[1] ? op_a : '1;
    else          special_val = funct3[1] ? '0 : MIN_INT;
  end

  // One radix-2 step. Multiply keeps {partial_hi, multiplier_lo} in acc;
  // divide keeps {remainder, dividend/quotient} in acc.
  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift - {1'b0, opnd};
    if (func[2])
      acc_step = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc[W-2:0], div_ge};
    else
      acc_step = {mul_sum, acc[W-1:1]};
  end

  // Sign fix-up of the unsigned core result, applied as the last step lands.
  always_comb begin
    prod = neg_res ? -acc_step : acc_step;
    core = func[1] ? acc_step[2*W-1:W] : acc_step[W-1:0];
    if (func[2])                fin_val = neg_res ? -core : core;
    else if (func[1:0] == 2'b00) fin_val = prod[W-1:0];
    else                        fin_val = prod[2*W-1:W];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = special ? FIN : CALC;
      CALC:    if (cnt == LAST_STEP) state_next = FIN;
      FIN:     state_next = start ? (special ? FIN : CALC) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt     <= '0;
      func    <= '0;
      neg_res <= 1'b0;
      acc     <= '0;
      opnd    <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else if (accept) begin
      cnt     <= '0;
      func    <= funct3;
      rd_out  <= rd_in;
      neg_res <= (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
      if (special) result <= special_val;
      if (funct3[2]) begin
        acc  <= {{W{1'b0}}, a_mag};
        opnd <= b_mag;
      end else begin
        acc  <= {{W{1'b0}}, b_mag};
        opnd <= a_mag;
      end
    end else if (state == CALC) begin
      acc <= acc_step;
      cnt <= cnt + 5'd1;
      if (cnt == LAST_STEP) result <= fin_val;
    end
  end

endmodule

// File: tb/tb_unidad_muldiv.sv
// Self-checking bench for unidad_muldiv: directed table, corner sequences
// (busy rejection, back-to-back, reset abort) and randomized ops against a model.
module tb_unidad_muldiv;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;

  unidad_muldiv #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model from the RV32M definitions using wide integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = 64'(ua * ub); return p[31:0];  end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = 64'(ua * ub); return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if (f[2] && !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Issue one op and wait for done; lat counts cycles from accept to done (0 = timeout).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res,
                        output logic [4:0] rdo, output int lat);
    bit seen;
    @(negedge CLK);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done) begin
        lat = k + 1; seen = 1'b1;
      end else begin
        @(posedge CLK); #1;
      end
    end
    res = result; rdo = rd_out;
    if (seen) begin
      @(posedge CLK); #1;
      check("done_one_cycle", {63'b0, done}, 64'd0);
      check("busy_released", {63'b0, busy}, 64'd0);
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd,
                              input logic [31:0] exp, input int lat);
    mk.name = n; mk.f = f; mk.a = a; mk.b = b; mk.rd = rd; mk.exp = exp; mk.lat = lat;
  endfunction

  vec_t vecs[12];

  initial begin
    logic [31:0] res, exp_r;
    logic [4:0]  rdo, rd_r;
    logic [2:0]  f_r;
    logic [31:0] a_r, b_r;
    int          lat, pulses;
    bit          seen;

    vecs[0]  = mk("mul_7_neg3",   3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    vecs[1]  = mk("mulh_min_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33);
    vecs[2]  = mk("mulhu_ones",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33);
    vecs[3]  = mk("mulhsu_ones",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33);
    vecs[4]  = mk("div_neg7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33);
    vecs[5]  = mk("rem_neg7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33);
    vecs[6]  = mk("divu_100_7",   3'b101, 32'd100,       32'd7,         5'd11, 32'h0000_000E, 33);
    vecs[7]  = mk("remu_100_7",   3'b111, 32'd100,       32'd7,         5'd12, 32'h0000_0002, 33);
    vecs[8]  = mk("div_by_zero",  3'b100, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1);
    vecs[9]  = mk("remu_by_zero", 3'b111, 32'd5,         32'd0,         5'd14, 32'h0000_0005, 1);
    vecs[10] = mk("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    vecs[11] = mk("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1);

    RESET_N = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    #12;
    check("reset_busy",   {63'b0, busy}, 64'd0);
    check("reset_done",   {63'b0, done}, 64'd0);
    check("reset_result", {32'b0, result}, 64'd0);
    check("reset_rd_out", {59'b0, rd_out}, 64'd0);
    @(negedge CLK); RESET_N = 1'b1;

    // Directed vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, res, rdo, lat);
      check({vecs[i].name, "_result"},  {32'b0, res}, {32'b0, vecs[i].exp});
      check({vecs[i].name, "_rd_out"},  {59'b0, rdo}, {59'b0, vecs[i].rd});
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
    end

    // Busy rejection: second start during CALC is dropped.
    @(negedge CLK);
    funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; rd_in = 5'd4; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    funct3 = 3'b000; op_a = 32'd4; op_b = 32'd4; rd_in = 5'd7; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    pulses = 0; res = '0; rdo = '0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin pulses++; res = result; rdo = rd_out; end
      @(posedge CLK); #1;
    end
    check("reject_pulses", 64'(pulses), 64'd1);
    check("reject_result", {32'b0, res}, 64'd6);
    check("reject_rd_out", {59'b0, rdo}, 64'd4);
    run_op(3'b000, 32'd4, 32'd4, 5'd7, res, rdo, lat);
    check("after_reject_result", {32'b0, res}, 64'd16);
    check("after_reject_latency", 64'(lat), 64'd33);

    // Back-to-back: a start held in the FIN cycle is taken on the IDLE-return edge.
    @(negedge CLK);
    funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6; rd_in = 5'd3; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin @(posedge CLK); #1; end
    end
    check("b2b_first_result", {32'b0, result}, 64'd30);
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    check("b2b_busy_kept", {63'b0, busy}, 64'd1);
    check("b2b_done_low",  {63'b0, done}, 64'd0);
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done) begin lat = k + 1; seen = 1'b1; end
      else begin @(posedge CLK); #1; end
    end
    check("b2b_second_result",  {32'b0, result}, 64'd14);
    check("b2b_second_rd_out",  {59'b0, rd_out}, 64'd9);
    check("b2b_second_latency", 64'(lat), 64'd33);
    @(posedge CLK); #1;

    // Reset mid-operation aborts with no done pulse.
    @(negedge CLK);
    funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd8; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    repeat (9) @(posedge CLK);
    #3 RESET_N = 1'b0;
    #1;
    check("abort_busy",   {63'b0, busy}, 64'd0);
    check("abort_done",   {63'b0, done}, 64'd0);
    check("abort_result", {32'b0, result}, 64'd0);
    check("abort_rd_out", {59'b0, rd_out}, 64'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK); RESET_N = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    run_op(3'b101, 32'd1000, 32'd3, 5'd8, res, rdo, lat);
    check("post_reset_result",  {32'b0, res}, 64'h14D);
    check("post_reset_latency", 64'(lat), 64'd33);

    // Randomized ops against the reference model.
    for (int n = 0; n < 48; n++) begin
      f_r  = 3'($urandom_range(0, 7));
      a_r  = $urandom;
      b_r  = $urandom;
      case ($urandom_range(0, 7))
        0: b_r = 32'd0;
        1: begin a_r = 32'h8000_0000; b_r = 32'hFFFF_FFFF; end
        2: b_r = 32'($urandom_range(1, 15));
        3: a_r = {a_r[31], 31'($urandom_range(0, 255))};
        default: ;
      endcase
      rd_r  = 5'($urandom);
      exp_r = model(f_r, a_r, b_r);
      run_op(f_r, a_r, b_r, rd_r, res, rdo, lat);
      check($sformatf("rand%0d_f%0d_%h_%h_result", n, f_r, a_r, b_r), {32'b0, res}, {32'b0, exp_r});
      check($sformatf("rand%0d_rd_out", n), {59'b0, rdo}, {59'b0, rd_r});
      check($sformatf("rand%0d_latency", n), 64'(lat), 64'(model_lat(f_r, a_r, b_r)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
